// File: rtl/benes_xbar_route.sv
// benes_xbar_route
//   Routes SIZE data lanes through a (2*log2(SIZE)-1)-stage Benes switch
//   fabric driven by a stored control word. The fabric is cut into NREG
//   elastic pipeline registers of PIPE_EVERY stages each. Throughput is
//   one beat per cycle, and latency is NREG cycles from accept to out_valid.
//
// Ports
//   clk, n_rst             clock, asynchronous active-low reset
//   cfg_valid/cfg_ready    control-word handshake; a word loads only while
//                          the pipeline is empty
//   cfg_ctrl               Benes control bits; stage k uses bits
//                          [k*SIZE/2 +: SIZE/2]
//   in_valid/in_ready      input beat handshake
//   in_data                lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready    output beat handshake
//   out_data               routed lanes, same packing as in_data
//   busy                   some pipeline register holds a valid beat
module benes_xbar_route #(
    parameter int unsigned SIZE       = 32,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PIPE_EVERY = 3
) (
    input  logic                                           clk,
    input  logic                                           n_rst,
    input  logic                                           cfg_valid,
    output logic                                           cfg_ready,
    input  logic [(2*$clog2(SIZE)-1)*(SIZE/2)-1:0]          cfg_ctrl,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [SIZE*DATA_WIDTH-1:0]                     in_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [SIZE*DATA_WIDTH-1:0]                     out_data,
    output logic                                           busy
);

    localparam int unsigned TAGWIDTH = $clog2(SIZE);
    localparam int unsigned STAGES   = 2*TAGWIDTH - 1;
    localparam int unsigned HALF     = SIZE/2;
    localparam int unsigned BITWIDTH = STAGES*HALF;
    localparam int unsigned NREG     = (STAGES + PIPE_EVERY - 1)/PIPE_EVERY;
    localparam int unsigned LW       = SIZE*DATA_WIDTH;

    logic [BITWIDTH-1:0] ctrl_q;
    logic                ctrl_loaded;
    logic [NREG-1:0]     vld_q;
    logic [NREG-1:0]     adv;
    logic [NREG-1:0]     up_vld;
    logic [LW-1:0]       data_q    [NREG];
    logic [LW-1:0]       src       [NREG];
    logic [LW-1:0]       stage_out [NREG];
    logic                in_fire;

    // One switch column: stride d rises 1,2,..,SIZE/2 and then falls back.
    // Switch j pairs lanes a and a+d; a set bit exchanges them.
    function automatic logic [LW-1:0] apply_stage(
        input logic [LW-1:0]   v,
        input int unsigned     k,
        input logic [HALF-1:0] bits
    );
        logic [LW-1:0] r;
        int unsigned   s;
        int unsigned   d;
        int unsigned   a;
        int unsigned   b;
        r = v;
        s = (k < TAGWIDTH) ? k : (2*TAGWIDTH - 2 - k);
        d = 32'd1 << s;
        for (int unsigned j = 0; j < HALF; j++) begin
            a = (j/d)*2*d + (j%d);
            b = a + d;
            if (bits[j]) begin
                r[a*DATA_WIDTH +: DATA_WIDTH] = v[b*DATA_WIDTH +: DATA_WIDTH];
                r[b*DATA_WIDTH +: DATA_WIDTH] = v[a*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return r;
    endfunction

    // A pending cfg_valid blocks new data so no beat is routed with a
    // control word that changes while it is in flight.
    assign in_fire   = in_valid && in_ready;
    assign busy      = |vld_q;
    assign cfg_ready = !busy && !in_fire;
    assign in_ready  = ctrl_loaded && !cfg_valid && adv[0];
    assign out_valid = vld_q[NREG-1];
    assign out_data  = data_q[NREG-1];

    // Ready chain from the output back: a register may take new data when
    // it is empty or when everything after it is able to move.
    always_comb begin
        adv = '0;
        adv[NREG-1] = !vld_q[NREG-1] || out_ready;
        for (int unsigned i = NREG-1; i > 0; i--) begin
            adv[i-1] = !vld_q[i-1] || adv[i];
        end
    end

    always_comb begin
        up_vld    = '0;
        up_vld[0] = in_fire;
        for (int unsigned r = 1; r < NREG; r++) begin
            up_vld[r] = vld_q[r-1];
        end
    end

    // Combinational slice of the fabric in front of each register.
    always_comb begin
        int unsigned lo;
        int unsigned hi;
        src[0] = in_data;
        for (int unsigned r = 1; r < NREG; r++) begin
            src[r] = data_q[r-1];
        end
        for (int unsigned r = 0; r < NREG; r++) begin
            lo = r*PIPE_EVERY;
            hi = (r+1)*PIPE_EVERY;
            if (hi > STAGES) begin
                hi = STAGES;
            end
            stage_out[r] = src[r];
            for (int unsigned k = lo; k < hi; k++) begin
                stage_out[r] = apply_stage(stage_out[r], k, ctrl_q[k*HALF +: HALF]);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ctrl_q      <= '0;
            ctrl_loaded <= 1'b0;
            vld_q       <= '0;
            for (int unsigned r = 0; r < NREG; r++) begin
                data_q[r] <= '0;
            end
        end else begin
            if (cfg_valid && cfg_ready) begin
                ctrl_q      <= cfg_ctrl;
                ctrl_loaded <= 1'b1;
            end
            // Data only updates on a real transfer so a stalled output
            // and idle registers keep their contents.
            for (int unsigned r = 0; r < NREG; r++) begin
                if (adv[r]) begin
                    vld_q[r] <= up_vld[r];
                    if (up_vld[r]) begin
                        data_q[r] <= stage_out[r];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_benes_xbar_route.sv
// tb_benes_xbar_route
//   Directed bench for benes_xbar_route at SIZE=32, DATA_WIDTH=8,
//   PIPE_EVERY=3 (9 stages, 144 control bits, 3 pipeline registers).
module tb_benes_xbar_route;

    localparam int unsigned SIZE = 32;
    localparam int unsigned DW   = 8;
    localparam int unsigned LW   = SIZE*DW;
    localparam int unsigned BW   = 144;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [BW-1:0] cfg_ctrl = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [LW-1:0] out_data;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    benes_xbar_route #(
        .SIZE       (32),
        .DATA_WIDTH (8),
        .PIPE_EVERY (3)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ctrl  (cfg_ctrl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [LW-1:0] ramp(input int unsigned base, input int unsigned step);
        logic [LW-1:0] v;
        for (int unsigned i = 0; i < SIZE; i++) begin
            v[i*DW +: DW] = 8'(base + i*step);
        end
        return v;
    endfunction

    function automatic logic [LW-1:0] swap_lanes(input logic [LW-1:0] v, input int unsigned a,
                                                 input int unsigned b);
        logic [LW-1:0] r;
        r = v;
        r[a*DW +: DW] = v[b*DW +: DW];
        r[b*DW +: DW] = v[a*DW +: DW];
        return r;
    endfunction

    // Reference: each output lane x looks up its switch j directly and
    // pulls from its partner lane x^d when that switch is set.
    function automatic logic [LW-1:0] model(input logic [BW-1:0] c, input logic [LW-1:0] din);
        logic [7:0]  cur [SIZE];
        logic [7:0]  nxt [SIZE];
        logic [LW-1:0] r;
        int unsigned s;
        int unsigned d;
        int unsigned j;
        for (int unsigned x = 0; x < SIZE; x++) cur[x] = din[x*DW +: DW];
        for (int unsigned k = 0; k < 9; k++) begin
            s = (k < 5) ? k : 8 - k;
            d = 1 << s;
            for (int unsigned x = 0; x < SIZE; x++) begin
                j = ((x >> (s+1)) << s) | (x & (d-1));
                nxt[x] = c[k*16 + j] ? cur[x ^ d] : cur[x];
            end
            for (int unsigned x = 0; x < SIZE; x++) cur[x] = nxt[x];
        end
        for (int unsigned x = 0; x < SIZE; x++) r[x*DW +: DW] = cur[x];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [BW-1:0] c);
        int n;
        cfg_ctrl  = c;
        cfg_valid = 1'b1;
        #1;
        n = 0;
        while (!cfg_ready && n < 100) begin
            tick();
            n++;
        end
        chk("cfg_ready_wait", LW'(cfg_ready), LW'(1));
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic send_one(input string tag, input logic [LW-1:0] d, input logic [LW-1:0] exp);
        int n;
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_in_ready"}, LW'(in_ready), LW'(1));
        tick();
        in_valid = 1'b0;
        #1;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_out_valid"}, LW'(out_valid), LW'(1));
        chk(tag, out_data, exp);
        tick();
    endtask

    initial begin
        logic [LW-1:0] e;
        logic [LW-1:0] b1;
        logic [LW-1:0] b2;
        logic [LW-1:0] b3;
        logic [LW-1:0] outq [4];
        logic [LW-1:0] held;
        logic [BW-1:0] c;
        logic [159:0]  rnd;
        logic          held_v;
        logic          ld_now;
        logic          snd_now;
        logic          loaded;
        int unsigned   got;
        int unsigned   sent;
        int unsigned   rcvd;
        int unsigned   cyc;
        logic [3:0]    pat;

        // Reset state, with in_valid offered so in_ready must stay low.
        in_valid = 1'b1;
        in_data  = ramp(0, 1);
        #12;
        chk("rst_out_valid", LW'(out_valid), LW'(0));
        chk("rst_out_data",  out_data,       '0);
        chk("rst_cfg_ready", LW'(cfg_ready), LW'(1));
        chk("rst_in_ready",  LW'(in_ready),  LW'(0));
        chk("rst_busy",      LW'(busy),      LW'(0));
        n_rst = 1'b1;
        tick();
        chk("noctrl_in_ready", LW'(in_ready), LW'(0));
        in_valid = 1'b0;

        // Identity word and exact three-cycle latency.
        load_cfg('0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = ramp(0, 1);
        #1;
        chk("lat_in_ready", LW'(in_ready), LW'(1));
        tick();
        in_valid = 1'b0;
        chk("lat_c1_valid", LW'(out_valid), LW'(0));
        tick();
        chk("lat_c2_valid", LW'(out_valid), LW'(0));
        tick();
        chk("lat_c3_valid", LW'(out_valid), LW'(1));
        chk("lat_c3_data",  out_data,       ramp(0, 1));
        tick();
        chk("drain_valid",     LW'(out_valid), LW'(0));
        chk("drain_busy",      LW'(busy),      LW'(0));
        chk("drain_cfg_ready", LW'(cfg_ready), LW'(1));

        // Single control bits, expected lanes worked out by hand.
        c = '0; c[0] = 1'b1;
        load_cfg(c);
        send_one("bit0", ramp(0, 1), swap_lanes(ramp(0, 1), 0, 1));
        c = '0; c[128] = 1'b1;
        load_cfg(c);
        send_one("bit128", ramp(0, 1), swap_lanes(ramp(0, 1), 0, 1));
        c = '0; c[64] = 1'b1;
        load_cfg(c);
        send_one("bit64", ramp(0, 1), swap_lanes(ramp(0, 1), 0, 16));
        c = '0; c[19] = 1'b1;
        load_cfg(c);
        send_one("bit19", ramp(0, 1), swap_lanes(ramp(0, 1), 5, 7));
        c = '0; c[0] = 1'b1; c[128] = 1'b1;
        load_cfg(c);
        send_one("bit0_128", ramp(0, 1), ramp(0, 1));
        c = '0; c[0] = 1'b1; c[64] = 1'b1;
        e = ramp(0, 1);
        e[0*DW +: DW]  = 8'd16;
        e[1*DW +: DW]  = 8'd0;
        e[16*DW +: DW] = 8'd1;
        load_cfg(c);
        send_one("bit0_64", ramp(0, 1), e);

        // Random control words against the reference.
        for (int unsigned t = 0; t < 40; t++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            c = rnd[BW-1:0];
            load_cfg(c);
            send_one("rand", ramp(t*3, 1), model(c, ramp(t*3, 1)));
        end

        // Ten back-to-back beats with out_ready cycling 1,0,0,1.
        c = '0; c[64] = 1'b1;
        load_cfg(c);
        pat = 4'b1001;
        sent = 0; rcvd = 0; cyc = 0; held_v = 1'b0; held = '0;
        while (rcvd < 10 && cyc < 200) begin
            in_valid  = (sent < 10);
            in_data   = ramp(sent*20, 1);
            out_ready = pat[cyc % 4];
            #1;
            if (held_v) begin
                chk("stall_valid", LW'(out_valid), LW'(1));
                chk("stall_data",  out_data,       held);
            end
            if (out_valid && out_ready) begin
                chk("stream_data", out_data, swap_lanes(ramp(rcvd*20, 1), 0, 16));
                rcvd++;
            end
            held_v = out_valid && !out_ready;
            held   = out_data;
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", LW'(rcvd), LW'(10));
        tick();
        tick();
        chk("stream_no_dup", LW'(out_valid), LW'(0));

        // New control word raised with two beats in flight.
        load_cfg('0);
        out_ready = 1'b1;
        b1 = ramp(100, 1);
        b2 = ramp(200, 3);
        b3 = ramp(50, 5);
        in_valid = 1'b1;
        in_data  = b1;
        tick();
        in_data = b2;
        tick();
        in_data   = b3;
        c = '0; c[0] = 1'b1;
        cfg_ctrl  = c;
        cfg_valid = 1'b1;
        #1;
        got = 0; cyc = 0; loaded = 1'b0;
        while (got < 3 && cyc < 40) begin
            if (cfg_valid) chk("midcfg_in_ready", LW'(in_ready), LW'(0));
            if (busy) chk("midcfg_cfg_ready", LW'(cfg_ready), LW'(0));
            if (out_valid) begin
                outq[got] = out_data;
                got++;
            end
            ld_now  = cfg_valid && cfg_ready;
            snd_now = in_valid && in_ready;
            tick();
            if (ld_now) begin
                cfg_valid = 1'b0;
                loaded    = 1'b1;
            end
            if (snd_now) in_valid = 1'b0;
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        chk("midcfg_loaded", LW'(loaded), LW'(1));
        chk("midcfg_count",  LW'(got),    LW'(3));
        chk("midcfg_beat1",  outq[0],     b1);
        chk("midcfg_beat2",  outq[1],     b2);
        chk("midcfg_beat3",  outq[2],     swap_lanes(b3, 0, 1));

        // Reset with three beats parked in the pipeline.
        tick();
        load_cfg('0);
        out_ready = 1'b0;
        sent = 0; cyc = 0;
        in_valid = 1'b1;
        while (sent < 3 && cyc < 20) begin
            in_data = ramp(sent*9, 1);
            #1;
            if (in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("rst_mid_sent",   LW'(sent),      LW'(3));
        chk("rst_mid_full",   LW'(out_valid), LW'(1));
        n_rst = 1'b0;
        #1;
        chk("rst_mid_out_valid", LW'(out_valid), LW'(0));
        chk("rst_mid_busy",      LW'(busy),      LW'(0));
        chk("rst_mid_out_data",  out_data,       '0);
        n_rst     = 1'b1;
        in_valid  = 1'b1;
        in_data   = ramp(7, 1);
        out_ready = 1'b1;
        #1;
        chk("rst_mid_in_ready", LW'(in_ready), LW'(0));
        tick();
        tick();
        chk("rst_mid_in_ready2", LW'(in_ready),  LW'(0));
        chk("rst_mid_idle",      LW'(out_valid), LW'(0));
        in_valid = 1'b0;
        c = '0; c[19] = 1'b1;
        load_cfg(c);
        send_one("rst_reload", ramp(7, 1), swap_lanes(ramp(7, 1), 5, 7));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/benes_xbar_route.md
Name: benes_xbar_route

Overview:
- Datapath consumer of the Benes control-bit generator.
- Takes a BITWIDTH-wide control word (same bit layout the generator emits) plus SIZE data lanes, and routes the lanes through a (2*log2(SIZE)-1)-stage Benes switch fabric.
- Elastic, valid/ready pipelined. Sits in the common xbar path between the permutation-config source and vector lane consumers.

Parameters:
- SIZE, 32, number of lanes; power of two, >= 4.
- DATA_WIDTH, 8, bits per lane.
- PIPE_EVERY, 3, switch stages per pipeline register.
- TAGWIDTH (localparam), $clog2(SIZE), referred to as m.
- STAGES (localparam), 2*m-1.
- BITWIDTH (localparam), STAGES*SIZE/2.
- NREG (localparam), ceil(STAGES/PIPE_EVERY); pipeline depth.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  new control word offered.
- cfg_ready  out  1  control word may be loaded.
- cfg_ctrl  in  BITWIDTH  Benes control bits.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted this cycle when in_valid=1.
- in_data  in  SIZE*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  SIZE*DATA_WIDTH  routed lanes, same packing as in_data.
- busy  out  1  any pipeline register holds valid data.

Behaviour:
- Control layout:
  - Stage k uses bits ctrl_q[k*SIZE/2 + j], for j in 0..SIZE/2-1.
  - Stride d = 1<<k for k<m; d = 1<<(2m-2-k) for k>=m.
  - Switch j pairs lanes a = (j/d)*2d + (j%d) and b = a+d.
  - Bit=1 swaps: out[a]=in[b], out[b]=in[a]. Bit=0 passes through.
  - Stages are applied in order 0..STAGES-1.
- ctrl_q register:
  - Reset 0. A ctrl_loaded flag resets to 0.
  - Load on cfg_valid && cfg_ready at the clock edge; set ctrl_loaded=1.
  - cfg_ready = !busy && !in_valid_accepting, i.e. the pipeline is empty. Asserted the same cycle the last beat leaves.
- in_ready = ctrl_loaded && !cfg_valid && (reg0 empty || reg0 advancing).
  - A pending cfg_valid blocks new data, so no beat ever mixes control words.
- Pipeline:
  - Register r (0..NREG-1) captures the combinational result of stages [r*PIPE_EVERY, min((r+1)*PIPE_EVERY, STAGES)).
  - Each register has a valid bit and advances when empty or downstream is ready (full-throughput skid-free elastic chain). No bubbles under continuous out_ready=1.
- Latency: NREG cycles from accept to out_valid (3 at defaults). Throughput: 1 beat/cycle.
- out_valid/out_data come from the last register. Data held stable while out_valid && !out_ready.
- Reset values: all valid bits 0, out_valid=0, out_data=0, cfg_ready=1, in_ready=0, busy=0. Data registers reset to 0.
- Reset mid-operation: all in-flight beats are dropped, ctrl_loaded cleared, and a config reload is required.
- Simultaneous cfg_valid and in_valid: config wins, and in_ready=0 that cycle.
- cfg_valid while busy: the control word waits until drain, then loads, then data resumes the next cycle.
- The all-zero control word is the identity.

Test Plan:
- Reset, load cfg_ctrl=0, send lanes in_data[i]=i -> out_data lane i = i after exactly 3 cycles; cfg_ready=1 after drain.
- cfg_ctrl bit 0 only set -> lanes 0 and 1 swapped, others unchanged. Bit (STAGES-1)*16 only -> lanes 0/1 swapped. Bit 4*16 (stage 4, d=16) -> lanes 0 and 16 swapped.
- Random permutation through the control-bit generator into cfg_ctrl, lanes = i -> out lane values form exactly the permutation the generator was given, for 1000 random permutations.
- Stream 10 back-to-back beats with out_ready toggling 1,0,0,1 -> no beat lost or duplicated, order preserved, out_data stable while stalled.
- Raise cfg_valid with 2 beats in flight -> cfg_ready=0 and in_ready=0 until drained; the new control word applies only to later beats.
- Assert n_rst low with 3 beats in flight -> out_valid=0 immediately, in_ready=0 until a new config is loaded.
